life_grid_ctrl: RTL and testbench

- Generation sequencer for a toroidal Game-of-Life board of W x H cells held in registers.
- Evaluates one full row per cycle: W birth/survival evaluators run in parallel, using the standard rule.
- Runs a requested number of generations, double-buffers each one, and stops early when the board becomes stable.
- Sits between the host load/readback interface and the per-cell next-state logic.

---
 rtl/life_grid_if.sv | 28 ++
 rtl/life_grid_ctrl.sv | 127 ++++++++++++
 tb/tb_life_grid_ctrl.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/life_grid_if.sv
// Host-side bus of the Game-of-Life sequencer: row load, run control, readback, status.
interface life_grid_if #(
    parameter int W  = 8,
    parameter int AW = 3,
    parameter int GW = 8
);
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [W-1:0]  load_data;
    logic          start;
    logic [GW-1:0] gens;
    logic [AW-1:0] rd_addr;
    logic [W-1:0]  rd_data;
    logic          busy;
    logic          done;
    logic          stable;
    logic [GW-1:0] gen_count;

    modport master (
        output load_en, load_addr, load_data, start, gens, rd_addr,
        input  rd_data, busy, done, stable, gen_count
    );

    modport slave (
        input  load_en, load_addr, load_data, start, gens, rd_addr,
        output rd_data, busy, done, stable, gen_count
    );
endinterface

// File: rtl/life_grid_ctrl.sv
// Toroidal Game-of-Life generation sequencer: one row per cycle, double-buffered,
// early stop on a stable board.
module life_cell (
    input  logic [2:0] up,
    input  logic [2:0] mid,
    input  logic [2:0] dn,
    output logic       alive
);
    logic [3:0] cnt;

    // mid[1] is the cell itself and is excluded from the count
    always_comb begin
        cnt = {3'b0, up[0]} + {3'b0, up[1]} + {3'b0, up[2]}
            + {3'b0, mid[0]} + {3'b0, mid[2]}
            + {3'b0, dn[0]} + {3'b0, dn[1]} + {3'b0, dn[2]};
    end

    assign alive = (cnt == 4'd3) | (mid[1] & (cnt == 4'd2));
endmodule

module life_grid_ctrl #(
    parameter int W  = 8,
    parameter int H  = 8,
    parameter int AW = 3,
    parameter int GW = 8
) (
    input logic       clk,
    input logic       rst,
    life_grid_if.slave bus
);
    typedef enum logic [1:0] {IDLE, COMPUTE, SWAP, DONE} state_t;

    localparam logic [AW:0]   H_EXT    = (AW+1)'(H);
    localparam logic [AW-1:0] LAST_ROW = AW'(H - 1);

    state_t                 state, state_next;
    logic [H-1:0][W-1:0]    cur, nxt;
    logic [AW-1:0]          row, row_up, row_dn;
    logic [GW-1:0]          target, gen_count, gen_inc;
    logic                   stable, change;
    logic [W-1:0]           up_row, mid_row, dn_row, new_row, rd_data;

    assign row_up  = (row == '0) ? LAST_ROW : row - AW'(1);
    assign row_dn  = (row == LAST_ROW) ? '0 : row + AW'(1);
    assign up_row  = cur[row_up];
    assign mid_row = cur[row];
    assign dn_row  = cur[row_dn];
    assign gen_inc = gen_count + GW'(1);

    for (genvar c = 0; c < W; c++) begin : g_col
        localparam int CL = (c + W - 1) % W;
        localparam int CR = (c + 1) % W;
        life_cell u_cell (
            .up    ({up_row[CL],  up_row[c],  up_row[CR]}),
            .mid   ({mid_row[CL], mid_row[c], mid_row[CR]}),
            .dn    ({dn_row[CL],  dn_row[c],  dn_row[CR]}),
            .alive (new_row[c])
        );
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = (bus.gens == '0) ? DONE : COMPUTE;
            COMPUTE: if (row == LAST_ROW) state_next = SWAP;
            SWAP:    state_next = (!change || gen_inc == target) ? DONE : COMPUTE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur       <= '0;
            nxt       <= '0;
            row       <= '0;
            target    <= '0;
            gen_count <= '0;
            stable    <= 1'b0;
            change    <= 1'b0;
            rd_data   <= '0;
        end else begin
            rd_data <= ({1'b0, bus.rd_addr} < H_EXT) ? cur[bus.rd_addr] : '0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        target    <= bus.gens;
                        gen_count <= '0;
                        stable    <= 1'b0;
                        change    <= 1'b0;
                        row       <= '0;
                    end else if (bus.load_en && ({1'b0, bus.load_addr} < H_EXT)) begin
                        cur[bus.load_addr] <= bus.load_data;
                    end
                end
                COMPUTE: begin
                    nxt[row] <= new_row;
                    change   <= change | (new_row != mid_row);
                    row      <= row + AW'(1);
                end
                SWAP: begin
                    cur       <= nxt;
                    gen_count <= gen_inc;
                    // an unchanged generation still counts, then the run stops
                    if (!change) begin
                        stable <= 1'b1;
                    end else if (gen_inc != target) begin
                        change <= 1'b0;
                        row    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy      = (state == COMPUTE) || (state == SWAP);
    assign bus.done      = (state == DONE);
    assign bus.stable    = stable;
    assign bus.gen_count = gen_count;
    assign bus.rd_data   = rd_data;
endmodule

// File: tb/tb_life_grid_ctrl.sv
// Directed bench for life_grid_ctrl: table of board runs plus hand sequences for
// ignored inputs and reset mid-run.
module tb_life_grid_ctrl;
    localparam int W  = 8;
    localparam int H  = 8;
    localparam int AW = 4;
    localparam int GW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    life_grid_if #(.W(W), .AW(AW), .GW(GW)) bus ();

    life_grid_ctrl #(.W(W), .H(H), .AW(AW), .GW(GW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit                  do_load;
        logic [7:0][7:0]     init;
        logic [7:0]          g;
        logic [7:0][7:0]     expb;
        int                  exp_done;
        int                  exp_gc;
        int                  exp_st;
    } vec_t;

    vec_t vec[8];

    localparam logic [63:0] B_EMPTY  = 64'h0000_0000_0000_0000;
    localparam logic [63:0] B_HORIZ  = 64'h0000_0000_1C00_0000;
    localparam logic [63:0] B_VERT   = 64'h0000_0008_0808_0000;
    localparam logic [63:0] B_GLIDER = 64'h0000_0000_0007_0402;
    localparam logic [63:0] B_BLOCK  = 64'h0000_3030_0000_0000;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic load_board(input logic [7:0][7:0] b);
        for (int r = 0; r < H; r++) begin
            @(negedge clk);
            bus.load_en   = 1'b1;
            bus.load_addr = AW'(r);
            bus.load_data = b[r];
        end
        @(negedge clk);
        bus.load_addr = AW'(9);
        bus.load_data = 8'hFF;
        @(negedge clk);
        bus.load_en = 1'b0;
    endtask

    task automatic read_row(input int addr, output logic [7:0] d);
        @(negedge clk);
        bus.rd_addr = AW'(addr);
        @(negedge clk);
        d = bus.rd_data;
    endtask

    task automatic check_board(input string name, input logic [7:0][7:0] expb);
        logic [7:0] d;
        for (int r = 0; r < H; r++) begin
            read_row(r, d);
            check($sformatf("%s row%0d", name, r), int'(d), int'(expb[r]));
        end
    endtask

    // start sampled at edge 0; the first negedge afterwards is cycle 1
    task automatic run(input logic [7:0] g, input int inject,
                       output int done_cyc, output int busy_cnt);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.gens  = g;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        done_cyc = -1;
        busy_cnt = 0;
        while (cyc <= 600) begin
            if (cyc == inject) begin
                bus.load_en   = 1'b1;
                bus.load_addr = '0;
                bus.load_data = 8'hFF;
                bus.start     = 1'b1;
                bus.gens      = 8'd5;
            end else if (cyc == inject + 1) begin
                bus.load_en = 1'b0;
                bus.start   = 1'b0;
            end
            if (bus.busy) busy_cnt++;
            if (bus.done) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check("done single pulse", int'(bus.done), 0);
    endtask

    initial begin
        int         dc, bc, pulses;
        logic [7:0] d;

        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.start     = 1'b0;
        bus.gens      = '0;
        bus.rd_addr   = '0;

        repeat (3) @(negedge clk);
        check("reset busy",      int'(bus.busy),      0);
        check("reset done",      int'(bus.done),      0);
        check("reset stable",    int'(bus.stable),    0);
        check("reset gen_count", int'(bus.gen_count), 0);
        check("reset rd_data",   int'(bus.rd_data),   0);
        rst = 1'b0;
        check_board("reset", B_EMPTY);

        vec[0] = '{1'b1, B_HORIZ,  8'd1,  B_VERT,   10,  1,  0};
        vec[1] = '{1'b0, B_EMPTY,  8'd1,  B_HORIZ,  10,  1,  0};
        vec[2] = '{1'b1, B_GLIDER, 8'd32, B_GLIDER, 289, 32, 0};
        vec[3] = '{1'b1, B_BLOCK,  8'd5,  B_BLOCK,  10,  1,  1};
        vec[4] = '{1'b1, B_HORIZ,  8'd0,  B_HORIZ,  1,   0,  0};
        vec[5] = '{1'b1, B_HORIZ,  8'd2,  B_HORIZ,  19,  2,  0};
        vec[6] = '{1'b1, B_HORIZ,  8'd3,  B_VERT,   28,  3,  0};
        vec[7] = '{1'b1, B_EMPTY,  8'd3,  B_EMPTY,  10,  1,  1};

        for (int i = 0; i < 8; i++) begin
            if (vec[i].do_load) load_board(vec[i].init);
            run(vec[i].g, 0, dc, bc);
            check($sformatf("v%0d done cycle", i), dc, vec[i].exp_done);
            check($sformatf("v%0d busy cycles", i), bc, vec[i].exp_gc * (H + 1));
            check($sformatf("v%0d gen_count", i), int'(bus.gen_count), vec[i].exp_gc);
            check($sformatf("v%0d stable", i), int'(bus.stable), vec[i].exp_st);
            check_board($sformatf("v%0d", i), vec[i].expb);
        end

        // load/start during COMPUTE: a honoured row-0 write would turn row 7 fully alive
        load_board(B_HORIZ);
        run(8'd1, 3, dc, bc);
        check("ignored done cycle", dc, 10);
        check("ignored gen_count", int'(bus.gen_count), 1);
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done) pulses++;
            check("ignored no rerun busy", int'(bus.busy), 0);
        end
        check("ignored extra done", pulses, 0);
        check_board("ignored", B_VERT);

        // readback range and reset in cycle 5 of a 3-generation run
        load_board(B_HORIZ);
        read_row(9, d);
        check("rd_addr 9", int'(d), 0);
        read_row(3, d);
        check("rd_addr 3", int'(d), 8'h1C);
        @(negedge clk);
        bus.start = 1'b1;
        bus.gens  = 8'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        check("busy before reset", int'(bus.busy), 1);
        rst = 1'b1;
        #1;
        check("busy at reset", int'(bus.busy), 0);
        check("done at reset", int'(bus.done), 0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        repeat (30) begin
            @(negedge clk);
            if (bus.done || bus.busy) pulses++;
        end
        check("post reset activity", pulses, 0);
        check("post reset gen_count", int'(bus.gen_count), 0);
        check_board("post reset", B_EMPTY);
        read_row(9, d);
        check("post reset rd_addr 9", int'(d), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
